// File: rtl/y_row_packer.sv
// ---------------------------------------------------------------------------
// y_row_packer
//
// Write-side packer for the Y SRAM row format. Nonzero complex matrix entries
// arrive over a valid/ready handshake. They are packed four per 256-bit word
// and written to Y SRAM at consecutive addresses. The stream is terminated by
// an EOF word, which lets the compute-side arbiter and selector stop cleanly.
//
// Word layout: slot k sits at WriteBus[64k+63:64k], and slot 0 is filled first.
//   slot = {valid, eof, diag, col[12:0], element[47:0]}
// Unused slots are written as zero. A row never spans words, so every row
// starts at slot 0.
//
// Optional feature (compile-time macro ROW_CHECK_EN):
//   When defined, each row is checked for strictly ascending columns and for
//   exactly one diagonal entry. A violation sets the sticky err flag, and the
//   offending entry is still packed. When undefined, err is tied to 0.
//
// Ports
//   clock       in   1        rising-edge clock
//   reset       in   1        asynchronous active-low reset
//   start       in   1        pulse: restart at BASE_ADDR, clear done/ovf/err
//   in_valid    in   1        entry present
//   in_ready    out  1        entry accepted this cycle (high only while filling)
//   in_col      in   13       column index
//   in_diag     in   1        entry is the row diagonal
//   in_element  in   48       {real[47:24], imag[23:0]}
//   in_row_end  in   1        last entry of its row
//   in_mat_end  in   1        last entry of the matrix
//   WE          out  1        Y SRAM write enable, one cycle per word
//   WriteReq    out  ADDR_W   Y SRAM write address (holds while WE=0)
//   WriteBus    out  256      Y SRAM write data (holds while WE=0)
//   done        out  1        sticky: EOF word written
//   ovf         out  1        sticky: address space exhausted
//   err         out  1        sticky: row format violation
// ---------------------------------------------------------------------------
module y_row_packer #(
  parameter int SLOTS     = 4,
  parameter int ADDR_W    = 11,
  parameter int BASE_ADDR = 0,
  parameter int MAX_ADDR  = 2047
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [12:0]           in_col,
  input  logic                  in_diag,
  input  logic [47:0]           in_element,
  input  logic                  in_row_end,
  input  logic                  in_mat_end,
  output logic                  WE,
  output logic [ADDR_W-1:0]     WriteReq,
  output logic [64*SLOTS-1:0]   WriteBus,
  output logic                  done,
  output logic                  ovf,
  output logic                  err
);

  localparam int CNT_W = $clog2(SLOTS);
  // One extra address bit so that "one past MAX_ADDR" is representable.
  localparam logic [ADDR_W:0] BASE_A = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] MAX_A  = (ADDR_W+1)'(MAX_ADDR);
  // EOF marker: only the valid and EOF bits of slot 0 are set.
  localparam logic [64*SLOTS-1:0] EOF_WORD = (64*SLOTS)'(64'hC000_0000_0000_0000);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_FLUSH,
    S_EOF_WR,
    S_DONE,
    S_OVF
  } state_t;

  state_t                state;
  logic [ADDR_W:0]       addr;
  logic [64*SLOTS-1:0]   word_buf;
  logic [CNT_W-1:0]      cnt;
  logic                  eof_pend;

  logic [63:0]           new_slot;
  logic [64*SLOTS-1:0]   word_next;
  logic                  close_word;
  logic [ADDR_W:0]       addr_inc;
  logic                  addr_over;
  logic                  inc_over;

  assign in_ready = (state == S_FILL);

  assign new_slot = {1'b1, 1'b0, in_diag, in_col, in_element};

  // This is the word as it will look once the incoming entry lands in slot cnt.
  always_comb begin
    word_next = word_buf;
    word_next[{cnt, 6'd0} +: 64] = new_slot;
  end

  // The word closes on the last slot or at any row boundary. A full slot 3
  // that also ends a row produces exactly one write.
  assign close_word = (cnt == CNT_W'(SLOTS - 1)) | in_row_end | in_mat_end;
  assign addr_inc   = addr + 1'b1;
  assign addr_over  = (addr > MAX_A);
  assign inc_over   = (addr_inc > MAX_A);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      addr     <= '0;
      word_buf <= '0;
      cnt      <= '0;
      eof_pend <= 1'b0;
      WE       <= 1'b0;
      WriteReq <= '0;
      WriteBus <= '0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else if (start) begin
      // start aborts any partial word and takes priority over an accept.
      state    <= S_FILL;
      addr     <= BASE_A;
      word_buf <= '0;
      cnt      <= '0;
      eof_pend <= 1'b0;
      WE       <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_valid) begin
            if (close_word) begin
              word_buf <= '0;
              cnt      <= '0;
              if (addr_over) begin
                ovf   <= 1'b1;
                state <= S_OVF;
              end else begin
                WE       <= 1'b1;
                WriteReq <= addr[ADDR_W-1:0];
                WriteBus <= word_next;
                eof_pend <= in_mat_end;
                state    <= S_FLUSH;
              end
            end else begin
              word_buf <= word_next;
              cnt      <= cnt + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          WE   <= 1'b0;
          addr <= addr_inc;
          if (eof_pend) begin
            if (inc_over) begin
              ovf   <= 1'b1;
              state <= S_OVF;
            end else begin
              WE       <= 1'b1;
              WriteReq <= addr_inc[ADDR_W-1:0];
              WriteBus <= EOF_WORD;
              state    <= S_EOF_WR;
            end
          end else begin
            state <= S_FILL;
          end
        end
        S_EOF_WR: begin
          WE       <= 1'b0;
          addr     <= addr_inc;
          eof_pend <= 1'b0;
          done     <= 1'b1;
          state    <= S_DONE;
        end
        default: begin
          WE <= 1'b0;
        end
      endcase
    end
  end

`ifdef ROW_CHECK_EN
  logic        accept;
  logic        in_row;
  logic [12:0] prev_col;
  logic [1:0]  diag_cnt;
  logic [1:0]  diag_sum;
  logic        col_bad;
  logic        diag_bad;

  assign accept   = in_ready & in_valid;
  // The count saturates at 2: only "exactly one" matters.
  assign diag_sum = (diag_cnt == 2'd2) ? 2'd2 : diag_cnt + {1'b0, in_diag};
  assign col_bad  = in_row & (in_col <= prev_col);
  assign diag_bad = (in_row_end | in_mat_end) & (diag_sum != 2'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_row   <= 1'b0;
      prev_col <= '0;
      diag_cnt <= '0;
      err      <= 1'b0;
    end else if (start) begin
      in_row   <= 1'b0;
      diag_cnt <= '0;
      err      <= 1'b0;
    end else if (accept) begin
      if (col_bad | diag_bad) begin
        err <= 1'b1;
      end
      prev_col <= in_col;
      if (in_row_end | in_mat_end) begin
        in_row   <= 1'b0;
        diag_cnt <= '0;
      end else begin
        in_row   <= 1'b1;
        diag_cnt <= diag_sum;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
